mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single memory port between instruction fetch and the load/store path of the core. Holds one outstanding transaction at a time and gives the load/store path priority. A starvation guard keeps fetch from being locked out. Sits between the core (fetch and ls ports) and the memory interface (mem_* ports). Fetch reads can be flushed after a jump so that stale instructions are dropped.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
MAX_LS_RUN, 4, max consecutive ls grants while fetch is waiting (legal range 1..15)

Ports:
CLK  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held with if_addr until if_valid or if_flush
if_addr  input  ADDR_W  fetch address
if_flush  input  1  one-cycle pulse; cancels pending or in-flight fetch
if_valid  output  1  one-cycle pulse; if_data valid
if_data  output  DATA_W  fetched instruction
ls_req  input  1  load/store request; held with ls_* until its response pulse
ls_size  input  2  00 byte / 01 half / 10 word store; 11 = load
ls_addr  input  ADDR_W  load/store address
ls_wdata  input  DATA_W  store data
ls_rvalid  output  1  one-cycle pulse; ls_rdata valid (loads)
ls_rdata  output  DATA_W  load data, raw word
ls_wdone  output  1  one-cycle pulse; store accepted
mem_req  output  1  memory transaction active
mem_size  output  2  size code, same encoding as ls_size (fetch always 11)
mem_addr  output  ADDR_W  transaction address
mem_wdata  output  DATA_W  store data
mem_ack  input  1  one-cycle pulse; read data on mem_rdata or write taken
mem_rdata  input  DATA_W  read data, valid with mem_ack

Behaviour:
- States: IDLE, FETCH, LOAD, STORE. All outputs are registered.
- Reset: state IDLE; mem_req 0; mem_size 11; mem_addr, mem_wdata, if_data, ls_rdata 0; if_valid, ls_rvalid, ls_wdone 0; run counter 0; drop flag 0.
- Grant happens only in IDLE, based on requests sampled at the rising edge.
- Arbitration order:
  - ls_req and not (if_req and run == MAX_LS_RUN) -> LOAD if ls_size == 11, else STORE.
  - else if_req and not if_flush -> FETCH.
- Run counter:
  - +1 (saturating at MAX_LS_RUN) on an ls grant while if_req is high.
  - Cleared on a fetch grant, or when if_req is low in IDLE.
- Grant at edge t: mem_req = 1 from t+1, with mem_addr/mem_size/mem_wdata captured from the winner. These are held stable until mem_ack.
- mem_ack sampled at edge k:
  - mem_req drops at k+1.
  - The matching response pulse (if_valid, ls_rvalid or ls_wdone) is high for exactly the k+1 cycle, with data registered from mem_rdata.
  - State returns to IDLE at k+1, so the next grant is at edge k+1 and its mem_req is at k+2.
- Minimum turnaround is 1 idle cycle of mem_req between transactions.
- mem_ack while in IDLE is ignored.
- if_flush:
  - In IDLE: the current if_req is not granted that cycle.
  - In FETCH: the drop flag is set. mem_req is still held until mem_ack, because memory cannot abort. On that ack, if_valid stays 0 and the drop flag clears.
  - if_flush never affects LOAD or STORE.
- if_flush on the same edge as mem_ack in FETCH: the fetch data is dropped.
- Simultaneous ls_req and if_req with run < MAX_LS_RUN: ls wins.
- Simultaneous ls_req and if_req with run == MAX_LS_RUN: fetch wins, run clears.
- Response pulses never overlap; at most one is high per cycle.
- resetn low mid-transaction: immediate return to reset values with no response pulse. Requesters must re-issue.

Test Plan:
- Fetch only: if_req=1, if_addr=0x1000, mem_ack at 3rd cycle of mem_req with mem_rdata=0x00500093 -> mem_size=11, mem_addr=0x1000; if_valid pulse 1 cycle after ack, if_data=0x00500093.
- Store word: ls_req=1, ls_size=10, ls_addr=0x2004, ls_wdata=0xDEADBEEF, plus pending if_req -> store granted first, mem_wdata=0xDEADBEEF; ls_wdone pulses; fetch granted the cycle after ls_wdone.
- Starvation guard: ls_req and if_req both held high, MAX_LS_RUN=4, ack latency 1 -> grant sequence ls,ls,ls,ls,fetch,ls...
- Flush in flight: fetch granted to 0x1008, if_flush pulsed during FETCH, mem_ack with 0x12345678 -> no if_valid; next request granted normally.
- Flush coincident with ack: if_flush on the mem_ack edge -> if_valid stays 0.
- Reset mid-load: LOAD active, resetn low for 1 cycle -> mem_req 0 asynchronously, no ls_rvalid, state IDLE; late mem_ack ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one outstanding transaction at a time, ls-priority with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_LS_RUN = 4
) (
  input  logic              CLK,
  input  logic              resetn,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  // load/store port
  input  logic              ls_req,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_wdone,
  // memory port
  output logic              mem_req,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

  localparam logic [1:0] SizeLoad = 2'b11;
  localparam logic [3:0] RunMax   = 4'(MAX_LS_RUN);

  state_e            state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_wdone_q, ls_wdone_d;
  logic              ls_win;

  // ls loses only when fetch is waiting and ls has already used its full run
  assign ls_win = ls_req && !(if_req && (run_q == RunMax));

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    if_data_d   = if_data_q;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    ls_wdone_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (ls_win) begin
          state_d     = (ls_size == SizeLoad) ? StLoad : StStore;
          mem_req_d   = 1'b1;
          mem_size_d  = ls_size;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          if (!if_req) begin
            run_d = '0;
          end else if (run_q != RunMax) begin
            run_d = run_q + 4'd1;
          end
        end else if (if_req && !if_flush) begin
          state_d    = StFetch;
          mem_req_d  = 1'b1;
          mem_size_d = SizeLoad;
          mem_addr_d = if_addr;
          run_d      = '0;
          drop_d     = 1'b0;
        end else if (!if_req) begin
          run_d = '0;
        end
      end
      StFetch: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // a flush on the ack edge itself also discards the data
          if (!(drop_q || if_flush)) begin
            if_valid_d = 1'b1;
            if_data_d  = mem_rdata;
          end
        end else if (if_flush) begin
          drop_d = 1'b1;
        end
      end
      StLoad: begin
        if (mem_ack) begin
          state_d     = StIdle;
          mem_req_d   = 1'b0;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_rdata;
        end
      end
      StStore: begin
        if (mem_ack) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          ls_wdone_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      run_q       <= '0;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_size_q  <= SizeLoad;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_data_q   <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_wdone_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      if_data_q   <= if_data_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_wdone_q  <= ls_wdone_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_data   = if_data_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_wdone  = ls_wdone_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MaxRun = 4;

  logic        CLK, resetn;
  logic        if_req, if_flush, if_valid;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_rvalid, ls_wdone;
  logic [1:0]  ls_size, mem_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_RUN(MaxRun)) dut (
    .CLK(CLK), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_data(if_data),
    .ls_req(ls_req), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_wdone(ls_wdone),
    .mem_req(mem_req), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_grant(input string name);
    for (int i = 0; i < 10 && !mem_req; i++) step();
    chk(name, mem_req, 1'b1);
  endtask

  task automatic drain();
    ls_req = 0; if_req = 0; if_flush = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ack = mem_req;
      step();
    end
    mem_ack = 0;
    step();
  endtask

  typedef struct packed {
    logic        ls;
    logic        fi;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic        e_lsr;
    logic        e_lsw;
  } vec_t;

  vec_t tbl [5];

  task automatic run_txn(input vec_t v);
    ls_req = v.ls; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
    if_req = v.fi; if_addr = v.addr;
    step();
    wait_grant("txn_grant");
    chk("txn_size", mem_size, v.e_size);
    chk("txn_addr", mem_addr, v.e_addr);
    if (v.ls) chk("txn_wdata", mem_wdata, v.wdata);
    step();
    chk("txn_hold_req", mem_req, 1'b1);
    chk("txn_hold_addr", mem_addr, v.e_addr);
    step();
    mem_ack = 1; mem_rdata = v.rdata;
    step();
    mem_ack = 0;
    chk("txn_if_valid", if_valid, v.e_ifv);
    chk("txn_ls_rvalid", ls_rvalid, v.e_lsr);
    chk("txn_ls_wdone", ls_wdone, v.e_lsw);
    chk("txn_req_drop", mem_req, 1'b0);
    if (v.e_ifv) chk("txn_if_data", if_data, v.rdata);
    if (v.e_lsr) chk("txn_ls_rdata", ls_rdata, v.rdata);
    ls_req = 0; if_req = 0;
    step();
    chk("txn_no_repeat", {if_valid, ls_rvalid, ls_wdone}, 3'b000);
  endtask

  // Reference model: tracks the single outstanding transaction and the ls run length.
  localparam int KFetch = 0, KLoad = 1, KStore = 2;
  bit          m_busy, m_drop, m_ifv, m_lsr, m_lsw;
  int          m_kind, m_run;
  logic [31:0] m_addr, m_wdata, m_if_data, m_ls_data;
  logic [1:0]  m_size;

  task automatic model_edge();
    m_ifv = 0; m_lsr = 0; m_lsw = 0;
    if (!m_busy) begin
      if (ls_req && !(if_req && m_run == MaxRun)) begin
        m_busy = 1;
        m_kind = (ls_size == 2'b11) ? KLoad : KStore;
        m_addr = ls_addr; m_size = ls_size; m_wdata = ls_wdata;
        m_run  = if_req ? ((m_run < MaxRun) ? m_run + 1 : MaxRun) : 0;
      end else if (if_req && !if_flush) begin
        m_busy = 1; m_kind = KFetch; m_addr = if_addr; m_size = 2'b11;
        m_run = 0; m_drop = 0;
      end else if (!if_req) begin
        m_run = 0;
      end
    end else if (mem_ack) begin
      m_busy = 0;
      if (m_kind == KFetch) begin
        if (!(m_drop || if_flush)) begin
          m_ifv = 1; m_if_data = mem_rdata;
        end
        m_drop = 0;
      end else if (m_kind == KLoad) begin
        m_lsr = 1; m_ls_data = mem_rdata;
      end else begin
        m_lsw = 1;
      end
    end else if (m_kind == KFetch && if_flush) begin
      m_drop = 1;
    end
  endtask

  int grants [6];
  int exp_grants [6];
  int ng;

  initial begin
    resetn = 0; if_req = 0; if_addr = 0; if_flush = 0;
    ls_req = 0; ls_size = 0; ls_addr = 0; ls_wdata = 0;
    mem_ack = 0; mem_rdata = 0;

    tbl[0] = {1'b0, 1'b1, 2'b11, 32'h0000_1000, 32'h0, 32'h0050_0093,
              2'b11, 32'h0000_1000, 1'b1, 1'b0, 1'b0};
    tbl[1] = {1'b1, 1'b0, 2'b11, 32'h0000_2000, 32'h1111_2222, 32'hCAFE_F00D,
              2'b11, 32'h0000_2000, 1'b0, 1'b1, 1'b0};
    tbl[2] = {1'b1, 1'b0, 2'b00, 32'h0000_2001, 32'h0000_00AA, 32'h5555_5555,
              2'b00, 32'h0000_2001, 1'b0, 1'b0, 1'b1};
    tbl[3] = {1'b1, 1'b0, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'h6666_6666,
              2'b01, 32'h0000_2002, 1'b0, 1'b0, 1'b1};
    tbl[4] = {1'b1, 1'b0, 2'b10, 32'h0000_2004, 32'hDEAD_BEEF, 32'h7777_7777,
              2'b10, 32'h0000_2004, 1'b0, 1'b0, 1'b1};
    exp_grants = '{0, 0, 0, 0, 1, 0};

    repeat (2) @(negedge CLK);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_size", mem_size, 2'b11);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_pulses", {if_valid, ls_rvalid, ls_wdone}, 3'b000);
    chk("rst_data", {if_data, ls_rdata}, 64'h0);
    resetn = 1;
    step();

    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // store with a pending fetch: store first, fetch right after ls_wdone
    ls_req = 1; ls_size = 2'b10; ls_addr = 32'h2004; ls_wdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h1000;
    step();
    wait_grant("sf_grant");
    chk("sf_store_first", mem_size, 2'b10);
    chk("sf_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("sf_wdone", {ls_wdone, if_valid}, 2'b10);
    ls_req = 0;
    step();
    chk("sf_fetch_next", {mem_req, mem_size}, 3'b111);
    chk("sf_fetch_addr", mem_addr, 32'h1000);
    mem_ack = 1; mem_rdata = 32'h0050_0093;
    step();
    mem_ack = 0;
    chk("sf_if_valid", if_valid, 1'b1);
    if_req = 0;
    step();

    // starvation guard with both requesters held and ack latency 1
    ls_req = 1; ls_size = 2'b11; ls_addr = 32'h3000;
    if_req = 1; if_addr = 32'h1000;
    ng = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      step();
      if (mem_req) begin
        grants[ng] = (mem_addr == 32'h3000) ? 0 : 1;
        ng++;
        mem_ack = 1;
      end else begin
        mem_ack = 0;
      end
    end
    chk("starve_count", ng, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("starve_grant%0d", i), grants[i], exp_grants[i]);
    drain();

    // flush while fetch in flight
    if_req = 1; if_addr = 32'h1008;
    step();
    wait_grant("fl_grant");
    chk("fl_addr", mem_addr, 32'h1008);
    if_flush = 1; if_req = 0;
    step();
    if_flush = 0;
    chk("fl_req_held", mem_req, 1'b1);
    step();
    mem_ack = 1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 0;
    chk("fl_no_valid", {if_valid, mem_req}, 2'b00);
    if_req = 1; if_addr = 32'h1010; mem_rdata = 32'h0BAD_C0DE;
    step();
    wait_grant("fl_next_grant");
    chk("fl_next_addr", mem_addr, 32'h1010);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("fl_next_valid", if_valid, 1'b1);
    chk("fl_next_data", if_data, 32'h0BAD_C0DE);
    if_req = 0;
    step();

    // flush on the same edge as ack
    if_req = 1; if_addr = 32'h1020;
    step();
    wait_grant("fc_grant");
    mem_ack = 1; if_flush = 1; if_req = 0; mem_rdata = 32'hFFFF_0000;
    step();
    mem_ack = 0; if_flush = 0;
    chk("fc_no_valid", {if_valid, mem_req}, 2'b00);
    step();
    chk("fc_still_none", if_valid, 1'b0);

    // reset in the middle of a load
    ls_req = 1; ls_size = 2'b11; ls_addr = 32'h4000;
    step();
    wait_grant("rl_grant");
    #2 resetn = 0; ls_req = 0;
    #1 chk("rl_async_req", mem_req, 1'b0);
    @(negedge CLK);
    resetn = 1; mem_ack = 1; mem_rdata = 32'hAAAA_5555;
    step();
    mem_ack = 0;
    chk("rl_no_rvalid", {ls_rvalid, mem_req}, 2'b00);
    chk("rl_reset_vals", {mem_size, mem_addr}, {2'b11, 32'h0});
    drain();

    // randomized traffic against the model
    m_busy = 0; m_drop = 0; m_run = 0; m_kind = KFetch;
    m_ifv = 0; m_lsr = 0; m_lsw = 0;
    for (int c = 0; c < 3000; c++) begin
      if_flush = 0;
      if (m_lsr || m_lsw) ls_req = 0;
      if (m_ifv) if_req = 0;
      if (!ls_req && $urandom_range(3) == 0) begin
        ls_req = 1; ls_size = 2'($urandom_range(3));
        ls_addr = $urandom; ls_wdata = $urandom;
      end
      if (if_req && $urandom_range(11) == 0) begin
        if_flush = 1; if_req = 1'($urandom_range(1)); if_addr = $urandom;
      end else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      mem_ack = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
      mem_rdata = $urandom;
      step();
      model_edge();
      chk("rnd_mem_req", mem_req, m_busy);
      if (m_busy) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_size", mem_size, m_size);
        if (m_kind != KFetch) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      chk("rnd_pulses", {if_valid, ls_rvalid, ls_wdone}, {m_ifv, m_lsr, m_lsw});
      if (m_ifv) chk("rnd_if_data", if_data, m_if_data);
      if (m_lsr) chk("rnd_ls_rdata", ls_rdata, m_ls_data);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
